// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: matches a runtime-loadable 1..MAX_LEN bit pattern, overlapping or not.
// Optional saturating match counter is built when SERIAL_PATTERN_DETECTOR_COUNT_EN is defined.
module serial_pattern_detector #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               data_in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  output logic               detected
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  if (MAX_LEN < 2 || CNT_W < 1) begin : g_param_check
    $error("serial_pattern_detector: MAX_LEN must be >= 2 and CNT_W >= 1");
  end

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] n);
    logic [MAX_LEN-1:0] m;
    m = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  logic [MAX_LEN-1:0] pat_r;
  logic [LW-1:0]      len_r;
  logic               ovl_r;
  // The oldest history bit is never compared again, so only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0] hist_r;
  logic [LW-1:0]      fill_r;
  logic               detected_r;

  logic               beat_s;
  logic [MAX_LEN-1:0] hist_n_s;
  logic [LW-1:0]      fill_n_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               match_s;
  logic [LW-1:0]      cfg_len_clamped_s;

  assign beat_s   = in_valid & ~cfg_load;
  assign hist_n_s = {hist_r, data_in};
  assign mask_s   = len_mask(len_r);

  // Next fill level, match decision and clamped configuration length.
  always_comb begin
    fill_n_s          = fill_r;
    match_s           = 1'b0;
    cfg_len_clamped_s = cfg_len;
    if (fill_r >= len_r) begin
      fill_n_s = len_r;
    end else begin
      fill_n_s = fill_r + LW'(1);
    end
    if ((len_r != LW'(0)) && (fill_n_s == len_r) &&
        ((hist_n_s & mask_s) == (pat_r & mask_s))) begin
      match_s = beat_s;
    end else begin
      match_s = 1'b0;
    end
    if (cfg_len > LW'(MAX_LEN)) begin
      cfg_len_clamped_s = LW'(MAX_LEN);
    end else begin
      cfg_len_clamped_s = cfg_len;
    end
  end

  // Configuration, history, fill level and the registered match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r      <= MAX_LEN'(3'b101);
      len_r      <= LW'(3);
      ovl_r      <= 1'b1;
      hist_r     <= {(MAX_LEN-1){1'b0}};
      fill_r     <= LW'(0);
      detected_r <= 1'b0;
    end else if (cfg_load) begin
      pat_r      <= cfg_pattern;
      len_r      <= cfg_len_clamped_s;
      ovl_r      <= cfg_overlap;
      hist_r     <= {(MAX_LEN-1){1'b0}};
      fill_r     <= LW'(0);
      detected_r <= 1'b0;
    end else if (beat_s) begin
      hist_r     <= hist_n_s[MAX_LEN-2:0];
      fill_r     <= match_s ? (ovl_r ? len_r : LW'(0)) : fill_n_s;
      detected_r <= match_s;
    end else begin
      detected_r <= 1'b0;
    end
  end

  assign detected = detected_r;

`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating match counter, cleared by reset and reconfiguration.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cfg_load) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (match_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign match_count = cnt_r;
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Self-checking bench for serial_pattern_detector; counter checks active with SERIAL_PATTERN_DETECTOR_COUNT_EN.
module tb_serial_pattern_detector;
  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               data_in = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = 8'h00;
  logic [LW-1:0]      cfg_len = 4'd0;
  logic               cfg_overlap = 1'b0;
  logic               detected;
  logic               detected2;
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
  logic [15:0]        match_count;
  logic [1:0]         match_count2;
`endif

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  serial_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .detected(detected)
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
    , .match_count(match_count)
`endif
  );

  serial_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .detected(detected2)
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
    , .match_count(match_count2)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic d);
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                          input logic v, input logic d);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    step(v, d);
    cfg_load    = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_det;
    apply_reset();
    exp_q.push_back(1'b0);
    exp_det = exp_q.pop_front();
    checks++;
    if (detected !== exp_det) begin
      errors++;
      $display("FAIL reset_detected: got %b want %b", detected, exp_det);
    end
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
    checks++;
    if (match_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", match_count);
    end
`endif
  endtask

  task automatic test_overlap_default();
    logic b[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic e[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_det;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(e[i]);
      step(1'b1, b[i]);
      exp_det = exp_q.pop_front();
      checks++;
      if (detected !== exp_det) begin
        errors++;
        $display("FAIL overlap_default beat %0d: got %b want %b", i + 1, detected, exp_det);
      end
    end
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
    checks++;
    if (match_count !== 16'd2) begin
      errors++;
      $display("FAIL overlap_default_count: got %0d want 2", match_count);
    end
`endif
  endtask

  task automatic test_non_overlap();
    logic b[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic e[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_det;
    load_cfg(8'b0000_0101, 4'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(e[i]);
      step(1'b1, b[i]);
      exp_det = exp_q.pop_front();
      checks++;
      if (detected !== exp_det) begin
        errors++;
        $display("FAIL non_overlap beat %0d: got %b want %b", i + 1, detected, exp_det);
      end
    end
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
    checks++;
    if (match_count !== 16'd1) begin
      errors++;
      $display("FAIL non_overlap_count: got %0d want 1", match_count);
    end
`endif
  endtask

  task automatic test_idle_gaps();
    logic v[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic b[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic e[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_det;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(e[i]);
      step(v[i], b[i]);
      exp_det = exp_q.pop_front();
      checks++;
      if (detected !== exp_det) begin
        errors++;
        $display("FAIL idle_gaps cycle %0d: got %b want %b", i, detected, exp_det);
      end
    end
  endtask

  task automatic test_max_len(input logic [3:0] l);
    logic exp_det;
    load_cfg(8'hFF, l, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      exp_q.push_back((i >= 8 && i <= 10) ? 1'b1 : 1'b0);
      step(i <= 10, 1'b1);
      exp_det = exp_q.pop_front();
      checks++;
      if (detected !== exp_det) begin
        errors++;
        $display("FAIL max_len len=%0d cycle %0d: got %b want %b", l, i, detected, exp_det);
      end
    end
  endtask

  task automatic test_cfg_collision();
    logic b[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic e[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_det;
    apply_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    exp_q.push_back(1'b0);
    load_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b1, 1'b1);
    exp_det = exp_q.pop_front();
    checks++;
    if (detected !== exp_det) begin
      errors++;
      $display("FAIL cfg_collision_load: got %b want %b", detected, exp_det);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e[i]);
      step(1'b1, b[i]);
      exp_det = exp_q.pop_front();
      checks++;
      if (detected !== exp_det) begin
        errors++;
        $display("FAIL cfg_collision beat %0d: got %b want %b", i + 1, detected, exp_det);
      end
    end
  endtask

  task automatic test_len_zero();
    logic exp_det;
    load_cfg(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'b0);
      step(1'b1, i[0]);
      exp_det = exp_q.pop_front();
      checks++;
      if (detected !== exp_det) begin
        errors++;
        $display("FAIL len_zero beat %0d: got %b want %b", i + 1, detected, exp_det);
      end
    end
  endtask

  task automatic test_back_to_back_saturate();
    logic b[3] = '{1'b1, 1'b0, 1'b1};
    logic e[3] = '{1'b0, 1'b0, 1'b1};
    logic exp_det;
    load_cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(1'b1);
      step(1'b1, 1'b1);
      exp_det = exp_q.pop_front();
      checks++;
      if (detected !== exp_det) begin
        errors++;
        $display("FAIL back_to_back beat %0d: got %b want %b", i + 1, detected, exp_det);
      end
    end
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
    checks++;
    if (match_count !== 16'd6) begin
      errors++;
      $display("FAIL count_16: got %0d want 6", match_count);
    end
    checks++;
    if (match_count2 !== 2'd3) begin
      errors++;
      $display("FAIL count_saturate: got %0d want 3", match_count2);
    end
`endif
    rst = 1'b1;
    exp_q.push_back(1'b0);
    step(1'b1, 1'b1);
    rst = 1'b0;
    exp_det = exp_q.pop_front();
    checks++;
    if ((detected !== exp_det) || (detected2 !== exp_det)) begin
      errors++;
      $display("FAIL mid_reset_detected: got %b/%b want %b", detected, detected2, exp_det);
    end
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
    checks++;
    if ((match_count !== 16'd0) || (match_count2 !== 2'd0)) begin
      errors++;
      $display("FAIL mid_reset_count: got %0d/%0d want 0", match_count, match_count2);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e[i]);
      step(1'b1, b[i]);
      exp_det = exp_q.pop_front();
      checks++;
      if (detected !== exp_det) begin
        errors++;
        $display("FAIL after_reset beat %0d: got %b want %b", i + 1, detected, exp_det);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap_default();
    test_non_overlap();
    test_idle_gaps();
    test_max_len(4'd8);
    test_max_len(4'd15);
    test_cfg_collision();
    test_len_zero();
    test_back_to_back_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Parametrised successor to the fixed "101" Moore detector. It matches a runtime-loadable serial bit pattern of 1..MAX_LEN bits, supports overlapping and non-overlapping match modes, accepts qualified input beats, and optionally counts matches. It sits on the serial data path wherever framing or sync-word recognition is required. Reset configuration reproduces the legacy "101" overlapping behaviour.

## Interface
- MAX_LEN, 8: longest supported pattern in bits; must be ≥2.
- CNT_W, 16: width of match counter; must be ≥1.
- LW: derived as $clog2(MAX_LEN+1); not user-set.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in is a valid beat this cycle.
- data_in  in  1  serial data bit.
- cfg_load  in  1  latch cfg_* this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is first-received, bit 0 last.
- cfg_len  in  LW  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- detected  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating match count (SERIAL_PATTERN_DETECTOR_COUNT_EN only).

## Operation
- Registers: pat[MAX_LEN], len[LW], ovl, hist[MAX_LEN] (bit 0 newest), fill[LW], detected, match_count.
- Reset: pat = 3'b101 zero-extended, len = 3, ovl = 1, hist = 0, fill = 0, detected = 0, match_count = 0.
- cfg_load: pat <= cfg_pattern, ovl <= cfg_overlap, len <= cfg_len clamped to MAX_LEN if larger, hist <= 0, fill <= 0, detected <= 0, match_count <= 0.
- cfg_len = 0 is accepted and disables matching; detected stays 0.
- Beat (in_valid & ~cfg_load): hist_n = {hist[MAX_LEN-2:0], data_in}; fill_n = min(fill+1, len).
- Match: len ≠ 0 & fill_n == len & hist_n[len-1:0] == pat[len-1:0]; unused upper pat bits are ignored.
- On match: detected <= 1. fill <= (ovl ? len : 0). hist <= hist_n in both modes. match_count increments and saturates at 2^CNT_W−1.
- No match, or no beat: detected <= 0. Without a beat, hist and fill hold.
- Priority: rst > cfg_load > beat. A beat coinciding with cfg_load is discarded.
- Non-overlap: a new match requires len fresh beats after the previous match.

## Timing
- Latency: detected is high in the cycle after the clock edge that accepts the completing beat. This matches the legacy Moore timing.
- detected is high for exactly one cycle per match. Back-to-back beats can produce pulses on consecutive cycles (overlap mode, e.g. an all-ones pattern).
- Idle cycles (in_valid = 0) between beats are transparent to matching.
- A new configuration is effective from the first beat accepted after the cfg_load cycle.
- rst mid-stream: partial history is discarded and the first match needs len fresh beats.
- First match no earlier than the len-th accepted beat after reset or cfg_load.

## Configuration
- SERIAL_PATTERN_DETECTOR_COUNT_EN defined: match_count port and counter exist; saturating, cleared by rst and cfg_load.
- Undefined: the port and counter are absent. detected behaviour is identical.

## Test plan
- Defaults, beats 1,0,1,0,1 every cycle -> detected pulses after beats 3 and 5; match_count = 2.
- cfg_load pattern 3'b101, len 3, overlap 0; beats 1,0,1,0,1 -> single pulse after beat 3; match_count = 1.
- Defaults, beats 1,0,1 with 2 idle cycles between each -> one pulse, one cycle after beat 3 is accepted, none earlier.
- cfg_load len = MAX_LEN, pattern all ones, overlap 1; 10 ones -> pulses after beats 8, 9, 10. cfg_len = 15 -> clamped, same result.
- cfg_load asserted with in_valid = 1 after beats 1,0 -> that bit is dropped; subsequent 1 does not match; full 1,0,1 does.
- CNT_W = 2, overlap 1, all-ones len 1, 6 beats -> 6 pulses, match_count stops at 3. rst pulse mid-stream -> all outputs 0 next cycle.
